// File: rtl/alu_op_sequencer.sv
// Operand-fetch sequencer for the ALU low-operand path: fetches 0-2 immediate bytes,
// keeps OP/OPold (stored inverted) and drives one registered select. Optional: ALU_OPSEQ_B2B_EN.
module alu_op_sequencer (
  input  logic       CLK,
  input  logic       notRST,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic [7:0] notOP,
  output logic [7:0] notOPold,
  output logic       PA_Select_OP_low,
  output logic       PA_Select_IOP_low,
  output logic       PA_Select_0xffOP_low,
  output logic       PA_Select_OPold_low,
  output logic       PA_Select_OPxx_low,
  output logic       notPA_Select_OPOPold_low,
  output logic       opnd_valid,
  input  logic       opnd_ack,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  localparam logic [5:0] SEL_NONE = 6'b000001;

  state_e     state_q, state_d;
  logic [2:0] mode_q, mode_d;
  logic [1:0] need_q, need_d;
  logic [7:0] notop_q, notop_d;
  logic [7:0] notopold_q, notopold_d;
  logic       err_q, err_d;
  logic       byte_ready_q, byte_ready_d;
  logic       opnd_valid_q, opnd_valid_d;
  logic       busy_q, busy_d;
  logic [5:0] sel_q, sel_d;
  logic       take_req_s;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= 3'd5);
  endfunction

  function automatic logic [1:0] bytes_needed(input logic [2:0] m);
    logic [1:0] n;
    case (m)
      3'd2:    n = 2'd2;
      3'd4:    n = 2'd0;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

  always_ff @(posedge CLK or negedge notRST) begin
    if (!notRST) begin
      state_q      <= ST_IDLE;
      mode_q       <= 3'd0;
      need_q       <= 2'd0;
      notop_q      <= 8'hFF;
      notopold_q   <= 8'hFF;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      opnd_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      sel_q        <= SEL_NONE;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      need_q       <= need_d;
      notop_q      <= notop_d;
      notopold_q   <= notopold_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      opnd_valid_q <= opnd_valid_d;
      busy_q       <= busy_d;
      sel_q        <= sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    need_d     = need_q;
    notop_d    = notop_q;
    notopold_d = notopold_q;
    err_d      = 1'b0;
    take_req_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          take_req_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Every accepted byte shifts OP into OPold (registers hold inverted values).
        if (byte_valid && byte_ready_q) begin
          notopold_d = notop_q;
          notop_d    = ~byte_data;
          need_d     = need_q - 2'd1;
          if (need_q == 2'd1) begin
            state_d = ST_VALID;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_VALID: begin
        if (opnd_ack) begin
          state_d = ST_IDLE;
`ifdef ALU_OPSEQ_B2B_EN
          take_req_s = start;
`else
          take_req_s = 1'b0;
`endif
        end else begin
          state_d = ST_VALID;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (take_req_s) begin
      if (mode_legal(mode)) begin
        mode_d = mode;
        need_d = bytes_needed(mode);
        if (bytes_needed(mode) != 2'd0) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_VALID;
        end
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // Outputs are precomputed from next state so they appear together with it.
  always_comb begin
    byte_ready_d = (state_d == ST_FETCH);
    opnd_valid_d = (state_d == ST_VALID);
    busy_d       = (state_d != ST_IDLE);
    sel_d        = SEL_NONE;
    if (state_d == ST_VALID) begin
      case (mode_d)
        3'd0:    sel_d = 6'b100001;
        3'd1:    sel_d = 6'b010001;
        3'd2:    sel_d = 6'b000000;
        3'd3:    sel_d = 6'b001001;
        3'd4:    sel_d = 6'b000101;
        3'd5:    sel_d = 6'b000011;
        default: sel_d = SEL_NONE;
      endcase
    end else begin
      sel_d = SEL_NONE;
    end
  end

  assign byte_ready               = byte_ready_q;
  assign notOP                    = notop_q;
  assign notOPold                 = notopold_q;
  assign opnd_valid               = opnd_valid_q;
  assign busy                     = busy_q;
  assign err                      = err_q;
  assign PA_Select_OP_low         = sel_q[5];
  assign PA_Select_IOP_low        = sel_q[4];
  assign PA_Select_0xffOP_low     = sel_q[3];
  assign PA_Select_OPold_low      = sel_q[2];
  assign PA_Select_OPxx_low       = sel_q[1];
  assign notPA_Select_OPOPold_low = sel_q[0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Table-driven bench for alu_op_sequencer plus hand sequences for ack+start and mid-fetch reset.
module tb_alu_op_sequencer;

  logic       CLK = 1'b0;
  logic       notRST;
  logic       start;
  logic [2:0] mode;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic [7:0] notOP, notOPold;
  logic       PA_Select_OP_low, PA_Select_IOP_low, PA_Select_0xffOP_low;
  logic       PA_Select_OPold_low, PA_Select_OPxx_low, notPA_Select_OPOPold_low;
  logic       opnd_valid;
  logic       opnd_ack;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  alu_op_sequencer dut (
    .CLK                      (CLK),
    .notRST                   (notRST),
    .start                    (start),
    .mode                     (mode),
    .byte_valid               (byte_valid),
    .byte_data                (byte_data),
    .byte_ready               (byte_ready),
    .notOP                    (notOP),
    .notOPold                 (notOPold),
    .PA_Select_OP_low         (PA_Select_OP_low),
    .PA_Select_IOP_low        (PA_Select_IOP_low),
    .PA_Select_0xffOP_low     (PA_Select_0xffOP_low),
    .PA_Select_OPold_low      (PA_Select_OPold_low),
    .PA_Select_OPxx_low       (PA_Select_OPxx_low),
    .notPA_Select_OPOPold_low (notPA_Select_OPOPold_low),
    .opnd_valid               (opnd_valid),
    .opnd_ack                 (opnd_ack),
    .busy                     (busy),
    .err                      (err)
  );

  typedef struct {
    logic       st;
    logic [2:0] md;
    logic       bv;
    logic [7:0] bd;
    logic       ack;
    logic [7:0] e_notop;
    logic [7:0] e_notopold;
    logic       e_rdy;
    logic       e_ov;
    logic [5:0] e_sel;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vecs[40];
  int   nvec = 0;

  function automatic logic [5:0] sel_now();
    return {PA_Select_OP_low, PA_Select_IOP_low, PA_Select_0xffOP_low,
            PA_Select_OPold_low, PA_Select_OPxx_low, notPA_Select_OPOPold_low};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [2:0] md, input logic bv, input logic [7:0] bd,
                     input logic ack, input logic [7:0] e_notop, input logic [7:0] e_notopold,
                     input logic e_rdy, input logic e_ov, input logic [5:0] e_sel,
                     input logic e_busy, input logic e_err);
    vecs[nvec] = '{st, md, bv, bd, ack, e_notop, e_notopold, e_rdy, e_ov, e_sel, e_busy, e_err};
    nvec++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] md, input logic bv,
                       input logic [7:0] bd, input logic ack);
    start      = st;
    mode       = md;
    byte_valid = bv;
    byte_data  = bd;
    opnd_ack   = ack;
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [7:0] e_notop,
                         input logic [7:0] e_notopold, input logic e_rdy, input logic e_ov,
                         input logic [5:0] e_sel, input logic e_busy, input logic e_err);
    chk({nm, ".notOP"},    idx, notOP,            e_notop);
    chk({nm, ".notOPold"}, idx, notOPold,         e_notopold);
    chk({nm, ".ready"},    idx, {7'd0, byte_ready}, {7'd0, e_rdy});
    chk({nm, ".ovalid"},   idx, {7'd0, opnd_valid}, {7'd0, e_ov});
    chk({nm, ".sel"},      idx, {2'd0, sel_now()},  {2'd0, e_sel});
    chk({nm, ".busy"},     idx, {7'd0, busy},       {7'd0, e_busy});
    chk({nm, ".err"},      idx, {7'd0, err},        {7'd0, e_err});
  endtask

  localparam logic [5:0] NONE = 6'b000001;

  initial begin
    // st md bv bd ack | notOP notOPold rdy ov sel busy err
    add(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 8'h3C, 1'b0, 8'hC3, 8'hFF, 1'b0, 1'b1, 6'b100001, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'hC3, 8'hFF, 1'b0, 1'b1, 6'b100001, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'hC3, 8'hFF, 1'b0, 1'b1, 6'b100001, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'hC3, 8'hFF, 1'b0, 1'b1, 6'b100001, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'hC3, 8'hFF, 1'b0, 1'b0, NONE,      1'b0, 1'b0);
    // mode 2 back-to-back bytes
    add(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 8'hC3, 8'hFF, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 8'h12, 1'b0, 8'hED, 8'hC3, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 8'h34, 1'b0, 8'hCB, 8'hED, 1'b0, 1'b1, 6'b000000, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'hCB, 8'hED, 1'b0, 1'b0, NONE,      1'b0, 1'b0);
    // mode 4 reuses OPold
    add(1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 8'hCB, 8'hED, 1'b0, 1'b1, 6'b000101, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'hCB, 8'hED, 1'b0, 1'b0, NONE,      1'b0, 1'b0);
    // mode 5 with 4-cycle stall, stray start ignored in FETCH
    add(1'b1, 3'd5, 1'b0, 8'h00, 1'b0, 8'hCB, 8'hED, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h99, 1'b0, 8'hCB, 8'hED, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b1, 3'd4, 1'b0, 8'h99, 1'b0, 8'hCB, 8'hED, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h99, 1'b0, 8'hCB, 8'hED, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h99, 1'b0, 8'hCB, 8'hED, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 8'h80, 1'b0, 8'h7F, 8'hCB, 1'b0, 1'b1, 6'b000011, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h7F, 8'hCB, 1'b0, 1'b0, NONE,      1'b0, 1'b0);
    // illegal mode
    add(1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 8'h7F, 8'hCB, 1'b0, 1'b0, NONE,      1'b0, 1'b1);
    add(1'b0, 3'd0, 1'b1, 8'h11, 1'b0, 8'h7F, 8'hCB, 1'b0, 1'b0, NONE,      1'b0, 1'b0);
    add(1'b1, 3'd6, 1'b0, 8'h00, 1'b0, 8'h7F, 8'hCB, 1'b0, 1'b0, NONE,      1'b0, 1'b1);
    // mode 1, byte_valid in VALID ignored
    add(1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 8'h7F, 8'hCB, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 8'h01, 1'b0, 8'hFE, 8'h7F, 1'b0, 1'b1, 6'b010001, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 8'h55, 1'b0, 8'hFE, 8'h7F, 1'b0, 1'b1, 6'b010001, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'hFE, 8'h7F, 1'b0, 1'b0, NONE,      1'b0, 1'b0);
    // mode 3
    add(1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 8'hFE, 8'h7F, 1'b1, 1'b0, NONE,      1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b1, 8'hAA, 1'b0, 8'h55, 8'hFE, 1'b0, 1'b1, 6'b001001, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h55, 8'hFE, 1'b0, 1'b0, NONE,      1'b0, 1'b0);

    notRST = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    step();
    chk_all("reset", 0, 8'hFF, 8'hFF, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
    notRST = 1'b1;
    step();

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].st, vecs[i].md, vecs[i].bv, vecs[i].bd, vecs[i].ack);
      step();
      chk_all("vec", i, vecs[i].e_notop, vecs[i].e_notopold, vecs[i].e_rdy, vecs[i].e_ov,
              vecs[i].e_sel, vecs[i].e_busy, vecs[i].e_err);
    end

    // ack together with start (mode 4) in VALID
    drive(1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b0, 3'd0, 1'b1, 8'h3C, 1'b0);
    step();
    chk_all("b2b_pre", 0, 8'hC3, 8'h55, 1'b0, 1'b1, 6'b100001, 1'b1, 1'b0);
    drive(1'b1, 3'd4, 1'b0, 8'h00, 1'b1);
    step();
`ifdef ALU_OPSEQ_B2B_EN
    chk_all("b2b_ack", 0, 8'hC3, 8'h55, 1'b0, 1'b1, 6'b000101, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b1);
    step();
    chk_all("b2b_end", 0, 8'hC3, 8'h55, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
`else
    chk_all("b2b_ack", 0, 8'hC3, 8'h55, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    step();
    chk_all("b2b_end", 0, 8'hC3, 8'h55, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
`endif

    // asynchronous reset mid-FETCH of mode 2 after one byte
    drive(1'b1, 3'd2, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b0, 3'd0, 1'b1, 8'h12, 1'b0);
    step();
    chk_all("rst_pre", 0, 8'hED, 8'hC3, 1'b1, 1'b0, NONE, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    #2;
    notRST = 1'b0;
    #1;
    chk_all("rst_mid", 0, 8'hFF, 8'hFF, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
    step();
    notRST = 1'b1;
    drive(1'b0, 3'd0, 1'b1, 8'h34, 1'b0);
    step();
    chk_all("rst_post", 0, 8'hFF, 8'hFF, 1'b0, 1'b0, NONE, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
